// File: rtl/comp_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comp_mult_pkg
//  Description : Shared constants for the complex-multiplier datapath:
//                operand-fetch FSM state encoding, operand byte indices
//                and memory words per complex operand.
//  Revision    : 1.0 - initial release
// ============================================================================
package comp_mult_pkg;

    // Operand-fetch FSM state encoding
    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_LAST  = 3'd2;
    localparam logic [2:0] c_S_VALID = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    // Byte index within one operation; this is also the memory read order.
    // Bit 1 selects operand array 2, bit 0 selects the imaginary (odd) word.
    localparam logic [1:0] c_IDX_X1 = 2'd0;
    localparam logic [1:0] c_IDX_Y1 = 2'd1;
    localparam logic [1:0] c_IDX_X2 = 2'd2;
    localparam logic [1:0] c_IDX_Y2 = 2'd3;

    // Memory words per complex operand (real, imaginary)
    localparam int c_BYTES_PER_OP = 2;

endpackage : comp_mult_pkg
`default_nettype wire

// File: rtl/comp_mult_op_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : comp_mult_op_fetch
//  Description : Fetches complex operand pairs {x1,x2,y1,y2} from memory
//                through a request/grant arbiter port and hands each
//                packet downstream with a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_mult_op_fetch
    import comp_mult_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int SYS_AW = 16,
    parameter int REG_DW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,      // asynchronous, active-high
    input  logic                  sw_rst,     // synchronous, active-high
    input  logic                  start,
    input  logic [REG_DW-1:0]     op1_addr,
    input  logic [REG_DW-1:0]     op2_addr,
    input  logic [REG_DW-1:0]     nr_op,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [SYS_AW-1:0]     mem_addr,
    input  logic [DWIDTH-1:0]     mem_rd_data,
    output logic                  op_val,
    input  logic                  op_rdy,
    output logic [4*DWIDTH-1:0]   op_data,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]           r_state;
    logic [REG_DW-1:0]    r_op_cnt;
    logic [1:0]           r_byte_idx;
    logic [SYS_AW-1:0]    r_op1_addr;
    logic [SYS_AW-1:0]    r_op2_addr;
    logic [REG_DW-1:0]    r_nr_op;
    logic                 r_rd_issued;
    logic [1:0]           r_rd_idx;
    logic [4*DWIDTH-1:0]  r_op_data;

    logic                 w_fetch;
    logic                 w_last_op;
    logic [SYS_AW-1:0]    w_base;
    logic [SYS_AW-1:0]    w_cnt_sys;
    logic [SYS_AW-1:0]    w_addr;

    assign w_fetch   = (r_state == c_S_FETCH);
    assign w_last_op = (r_op_cnt == (r_nr_op - REG_DW'(1)));

    // Address of the word selected by the byte index; wraps modulo 2^SYS_AW
    assign w_base    = r_byte_idx[1] ? r_op2_addr : r_op1_addr;
    assign w_cnt_sys = SYS_AW'(r_op_cnt);
    assign w_addr    = w_base
                     + (w_cnt_sys * SYS_AW'(c_BYTES_PER_OP))
                     + SYS_AW'(r_byte_idx[0]);

    assign mem_req  = w_fetch;
    assign mem_ce   = w_fetch & mem_gnt;
    assign mem_we   = 1'b0;
    assign mem_addr = w_fetch ? w_addr : '0;

    assign op_val   = (r_state == c_S_VALID);
    assign op_data  = r_op_data;
    assign busy     = (r_state != c_S_IDLE);
    assign done     = (r_state == c_S_DONE);

    // Job FSM with operation counter, byte index and configuration capture
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state    <= c_S_IDLE;
            r_op_cnt   <= '0;
            r_byte_idx <= c_IDX_X1;
            r_op1_addr <= '0;
            r_op2_addr <= '0;
            r_nr_op    <= '0;
        end else if (sw_rst) begin
            r_state    <= c_S_IDLE;
            r_op_cnt   <= '0;
            r_byte_idx <= c_IDX_X1;
            r_op1_addr <= '0;
            r_op2_addr <= '0;
            r_nr_op    <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_op1_addr <= op1_addr[SYS_AW-1:0];
                        r_op2_addr <= op2_addr[SYS_AW-1:0];
                        r_nr_op    <= nr_op;
                        r_op_cnt   <= '0;
                        r_byte_idx <= c_IDX_X1;
                        r_state    <= (nr_op != '0) ? c_S_FETCH : c_S_DONE;
                    end
                end
                c_S_FETCH: begin
                    // Index advances only on granted reads; wraps Y2 -> X1
                    if (mem_gnt) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == c_IDX_Y2) begin
                            r_state <= c_S_LAST;
                        end
                    end
                end
                c_S_LAST: begin
                    // y2 lands in op_data on this edge
                    r_state <= c_S_VALID;
                end
                c_S_VALID: begin
                    if (op_rdy) begin
                        if (w_last_op) begin
                            r_state <= c_S_DONE;
                        end else begin
                            r_op_cnt <= r_op_cnt + REG_DW'(1);
                            r_state  <= c_S_FETCH;
                        end
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Read data returns one cycle after the granted access; steer it into
    // the packet field named by the index that was issued with it
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_rd_issued <= 1'b0;
            r_rd_idx    <= c_IDX_X1;
            r_op_data   <= '0;
        end else if (sw_rst) begin
            r_rd_issued <= 1'b0;
            r_rd_idx    <= c_IDX_X1;
            r_op_data   <= '0;
        end else begin
            r_rd_issued <= mem_ce;
            r_rd_idx    <= r_byte_idx;
            if (r_rd_issued) begin
                case (r_rd_idx)
                    c_IDX_X1: r_op_data[4*DWIDTH-1:3*DWIDTH] <= mem_rd_data;
                    c_IDX_X2: r_op_data[3*DWIDTH-1:2*DWIDTH] <= mem_rd_data;
                    c_IDX_Y1: r_op_data[2*DWIDTH-1:DWIDTH]   <= mem_rd_data;
                    default:  r_op_data[DWIDTH-1:0]          <= mem_rd_data;
                endcase
            end
        end
    end

endmodule : comp_mult_op_fetch
`default_nettype wire
